mem_write: RTL
==============

# mem_write

Write-side counterpart of the skewed BRAM read fan-out. Collects result words from N systolic output columns, where column x lags column 0 by x cycles, and writes each column into its own BRAM bank at consecutive addresses from a common base. A transfer of `len` rows starts on a `start` pulse. The block reports `busy`, a one-cycle `done` pulse and a sticky `overrun` flag to the controller sequencing compute and writeback.

## Interface
- `D_W`, default 8: data width per column / bank word.
- `N`, default 4: number of columns and BRAM banks.
- `ADDR_W`, default 12: BRAM address width; also the width of `len`.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a transfer; honoured only in IDLE.
- `base_addr`  in  ADDR_W: first write address for every bank; sampled with `start`.
- `len`  in  ADDR_W: rows (words per bank) in the transfer; sampled with `start`.
- `in_data`  in  D_W × [N-1:0]: column result words, unpacked array.
- `in_valid`  in  N: per-column valid; column x is valid when `in_valid[x]`=1.
- `wr_addr_bram`  out  ADDR_W × [N-1:0]: per-bank write address, unpacked array.
- `wr_data_bram`  out  D_W × [N-1:0]: per-bank write data.
- `wr_en_bram`  out  N: per-bank write enable.
- `busy`  out  1: a transfer is in progress (RUN or DONE state).
- `done`  out  1: one-cycle pulse at the end of a transfer.
- `overrun`  out  1: sticky; a column was valid after its bank had already received `len` words.

## Operation
- States: IDLE, RUN, DONE. Reset: state=IDLE. All outputs are 0 at reset, including every array element. Counters are cleared and the latched base/len are 0.
- IDLE + `start`=1:
  - Latch `base_addr` and `len`.
  - Clear all N per-bank counters `cnt[x]` (ADDR_W bits) and clear `overrun`.
  - If `len`≠0, next state is RUN. If `len`=0, next state is DONE.
- IDLE + `start`=0: remain in IDLE. `in_valid` is ignored entirely: no writes, no `overrun` change.
- RUN, per bank x, evaluated every cycle independently:
  - If `in_valid[x]`=1 and `cnt[x]`<len: on the next cycle `wr_en_bram[x]`=1, `wr_addr_bram[x]`=base+`cnt[x]` (mod 2^ADDR_W, wrap silently), and `wr_data_bram[x]`=`in_data[x]`. Then `cnt[x]` increments.
  - If `in_valid[x]`=1 and `cnt[x]`=len: no write, and `overrun` is set to 1.
  - If `in_valid[x]`=0: `wr_en_bram[x]`=0 on the next cycle. `wr_addr_bram[x]` and `wr_data_bram[x]` hold their previous values.
- RUN → DONE in the cycle after every `cnt[x]` has reached len. This is the same cycle the last bank's final write appears on its ports.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored while in DONE.
- `start` in RUN or DONE is ignored and does not restart the transfer.
- Column skew is not enforced. Each bank tracks its own valids, so gaps and arbitrary per-column timing are tolerated.
- `overrun` stays set until the next accepted `start` or `rst`. Valids arriving in DONE are ignored and do not set `overrun`.
- `rst` mid-transfer: the next cycle is IDLE with all outputs 0. No `done` is produced. Any partially written data stays in the BRAMs.

## Timing
- Write latency: `in_valid[x]`/`in_data[x]` sampled at edge t appear on bank x ports after edge t+1. This is one register stage with identical latency for every bank.
- `busy` goes high the cycle after `start` is accepted. It stays high through the DONE cycle and is low the cycle after `done`.
- Fully skewed stream, len=L, column 0 first valid sampled at edge t0, column x at t0+x:
  - Bank x writes are visible in cycles t0+x+1 … t0+x+L.
  - `done` is high in cycle t0+N+L-1, coincident with bank N-1's final write.
- `len`=0: `busy`=1 and `done`=1 in the cycle after `start`, with no writes. `busy`=0 the cycle after that.
- Minimum spacing between accepted starts: 2 cycles after `done`. `start` sampled in the cycle after `done` is accepted.

## Test plan
- N=4, base=0x010, len=3; column x gets values 10x+r (r=0..2), skewed x cycles. Required:
  - Bank x writes 10x+r at addresses 0x010..0x012, in three consecutive cycles starting x+1 cycles after column 0's first valid.
  - `done` is one cycle, coincident with bank 3's final write. `overrun`=0.
- Gapped stream: column 2's valids arrive at cycles 0, 3 and 7 with len=3. Required: bank 2 addresses base, base+1, base+2 in order; `done` waits for the slowest bank.
- Overrun: len=2 and column 1 asserts valid three times. Required: exactly two bank-1 writes, `overrun`=1 until the next `start`, and `done` unaffected.
- Wrap and len=0: base=0xFFE, len=3, so addresses are 0xFFE, 0xFFF, 0x000. A `start` with len=0 gives `done` the next cycle with no `wr_en_bram` activity.
- Ignored inputs: valids in IDLE produce no writes. `start` asserted mid-RUN does not relatch base/len.
- Reset mid-transfer: `rst` after 1 of 3 rows, then all outputs 0 the next cycle and no `done`. A new `start` then completes normally from a fresh base.

Source files
------------

// File: rtl/mem_write.sv
// mem_write: skewed multi-column result writeback into N independent BRAM banks
// Ports: clk/rst (sync, active-high); start/base_addr/len launch a transfer of len rows;
//        in_data/in_valid carry per-column results; wr_addr_bram/wr_data_bram/wr_en_bram
//        drive each bank; busy/done/overrun report progress to the controller.
module mem_write #(
    parameter int D_W    = 8,
    parameter int N      = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [D_W-1:0]    in_data      [N-1:0],
    input  logic [N-1:0]      in_valid,
    output logic [ADDR_W-1:0] wr_addr_bram [N-1:0],
    output logic [D_W-1:0]    wr_data_bram [N-1:0],
    output logic [N-1:0]      wr_en_bram,
    output logic              busy,
    output logic              done,
    output logic              overrun
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              state_q;
    logic [ADDR_W-1:0]   base_q, len_q;
    logic [ADDR_W-1:0]   cnt_q [N-1:0];
    logic [ADDR_W-1:0]   cnt_d [N-1:0];
    logic [N-1:0]        take;
    logic                all_d;
    // all_d looks at the post-increment counts so DONE lines up with the last bank's final write
    always_comb begin
        take  = '0;
        cnt_d = cnt_q;
        all_d = 1'b1;
        for (int x = 0; x < N; x++) begin
            take[x]  = in_valid[x] && (cnt_q[x] < len_q);
            cnt_d[x] = cnt_q[x] + ADDR_W'(take[x]);
            all_d    = all_d && (cnt_d[x] == len_q);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            wr_en_bram <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            for (int x = 0; x < N; x++) begin
                cnt_q[x]        <= '0;
                wr_addr_bram[x] <= '0;
                wr_data_bram[x] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    wr_en_bram <= '0;
                    if (start) begin
                        base_q  <= base_addr;
                        len_q   <= len;
                        overrun <= 1'b0;
                        busy    <= 1'b1;
                        done    <= (len == '0);
                        state_q <= (len == '0) ? DONE : RUN;
                        for (int x = 0; x < N; x++) cnt_q[x] <= '0;
                    end
                end
                RUN: begin
                    for (int x = 0; x < N; x++) begin
                        wr_en_bram[x] <= take[x];
                        if (take[x]) begin
                            wr_addr_bram[x] <= base_q + cnt_q[x];
                            wr_data_bram[x] <= in_data[x];
                        end
                    end
                    cnt_q <= cnt_d;
                    if (|(in_valid & ~take)) overrun <= 1'b1;
                    if (all_d) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    wr_en_bram <= '0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end
endmodule
